// File: rtl/puncturer.sv
// ---------------------------------------------------------------------------
// puncturer
//   Sits after the rate-1/2 convolutional encoder. Each accepted coded pair
//   (A,B) is reduced to the bits kept by the 802.11a puncturing pattern:
//     rate 1/2 : period 1, keep A,B
//     rate 2/3 : period 2, phase 0 keeps A,B; phase 1 keeps A
//     rate 3/4 : period 3, phase 0 keeps A,B; phase 1 keeps A; phase 2 keeps B
//   The kept bits leave serially, A before B, toward the interleaver.
//
// Optional feature: define PUNCT_STATS_EN to build the saturating
// pairs_in / bits_out statistics counters. Without it the counter outputs
// are tied to 0 and no counter flops exist.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. out_valid never drops without a transfer except on reset or
// frame_start; out_bit is held stable while out_valid && !out_ready.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_frame_start  one-cycle pulse: latch i_rate, phase=0, drop pending bits
//   i_rate         00=1/2, 01=2/3, 10=3/4, 11=reserved (latched as 1/2)
//   i_in_valid     i_in_a/i_in_b hold a coded pair
//   i_in_a         encoder output A (g0 = 133 octal)
//   i_in_b         encoder output B (g1 = 171 octal)
//   o_in_ready     block accepts a pair this cycle
//   o_out_valid    o_out_bit is valid
//   o_out_bit      punctured serial bit
//   i_out_ready    downstream accepts o_out_bit this cycle
//   o_pairs_in     accepted pair count (PUNCT_STATS_EN only, else 0)
//   o_bits_out     emitted bit count   (PUNCT_STATS_EN only, else 0)
// ---------------------------------------------------------------------------
module puncturer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_frame_start,
    input  logic [1:0]       i_rate,
    input  logic             i_in_valid,
    input  logic             i_in_a,
    input  logic             i_in_b,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic             o_out_bit,
    input  logic             i_out_ready,
    output logic [CNT_W-1:0] o_pairs_in,
    output logic [CNT_W-1:0] o_bits_out
);

    localparam logic [1:0] RATE_1_2 = 2'b00;
    localparam logic [1:0] RATE_2_3 = 2'b01;
    localparam logic [1:0] RATE_3_4 = 2'b10;

    // r_alive holds in_ready low during reset and releases it on the first
    // edge after reset deasserts.
    logic       r_alive;
    logic [1:0] r_rate;
    logic [1:0] r_phase;
    // Holding register: r_bits[0] is the bit on the output, r_bits[1] the
    // one behind it; r_cnt is the number of pending bits (0..2).
    logic [1:0] r_bits;
    logic [1:0] r_cnt;

    logic       w_keep_a;
    logic       w_keep_b;
    logic [1:0] w_last_phase;
    logic [1:0] w_load_bits;
    logic [1:0] w_load_cnt;
    logic       w_push;
    logic       w_pop;

    assign o_out_valid = (r_cnt != 2'd0);
    assign o_out_bit   = r_bits[0];

    // A new pair may land when the register is empty or when its last bit
    // leaves this very cycle, which keeps the output stream bubble-free.
    assign o_in_ready = r_alive && !i_frame_start &&
                        ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && i_out_ready));

    assign w_push = i_in_valid && o_in_ready;
    assign w_pop  = o_out_valid && i_out_ready;

    // Puncturing pattern for the current phase.
    always_comb begin
        w_keep_a     = 1'b1;
        w_keep_b     = 1'b1;
        w_last_phase = 2'd0;
        case (r_rate)
            RATE_2_3: begin
                w_last_phase = 2'd1;
                if (r_phase == 2'd1) w_keep_b = 1'b0;
            end
            RATE_3_4: begin
                w_last_phase = 2'd2;
                if (r_phase == 2'd1)      w_keep_b = 1'b0;
                else if (r_phase == 2'd2) w_keep_a = 1'b0;
            end
            default: ;
        endcase
    end

    // Pack kept bits so the first one to send sits in bit 0; the unused
    // upper slot is zero so the output reads 0 once the register drains.
    always_comb begin
        w_load_bits = {1'b0, i_in_b};
        if (w_keep_a && w_keep_b) w_load_bits = {i_in_b, i_in_a};
        else if (w_keep_a)        w_load_bits = {1'b0, i_in_a};
        w_load_cnt = {1'b0, w_keep_a} + {1'b0, w_keep_b};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_alive <= 1'b0;
            r_rate  <= RATE_1_2;
            r_phase <= 2'd0;
            r_bits  <= 2'b00;
            r_cnt   <= 2'd0;
        end else begin
            r_alive <= 1'b1;
            if (i_frame_start) begin
                r_rate  <= (i_rate == 2'b11) ? RATE_1_2 : i_rate;
                r_phase <= 2'd0;
                r_bits  <= 2'b00;
                r_cnt   <= 2'd0;
            end else if (w_push) begin
                // in_ready guarantees the register is empty or emptying.
                r_bits  <= w_load_bits;
                r_cnt   <= w_load_cnt;
                r_phase <= (r_phase == w_last_phase) ? 2'd0 : r_phase + 2'd1;
            end else if (w_pop) begin
                r_bits <= {1'b0, r_bits[1]};
                r_cnt  <= r_cnt - 2'd1;
            end
        end
    end

`ifdef PUNCT_STATS_EN
    logic [CNT_W-1:0] r_pairs_in;
    logic [CNT_W-1:0] r_bits_out;
    // frame_start outranks a bit transfer in the same cycle.
    logic             w_bit_xfer;

    assign w_bit_xfer = w_pop && !i_frame_start;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pairs_in <= '0;
            r_bits_out <= '0;
        end else if (i_frame_start) begin
            r_pairs_in <= '0;
            r_bits_out <= '0;
        end else begin
            if (w_push && (r_pairs_in != {CNT_W{1'b1}}))
                r_pairs_in <= r_pairs_in + 1'b1;
            if (w_bit_xfer && (r_bits_out != {CNT_W{1'b1}}))
                r_bits_out <= r_bits_out + 1'b1;
        end
    end

    assign o_pairs_in = r_pairs_in;
    assign o_bits_out = r_bits_out;
`else
    assign o_pairs_in = '0;
    assign o_bits_out = '0;
`endif

endmodule

// File: tb/tb_puncturer.sv
// ---------------------------------------------------------------------------
// tb_puncturer
//   Directed and randomized stimulus for puncturer. A reference model keeps
//   the expected output bits in a queue (exp_q): each accepted pair appends
//   the bits its pattern position keeps, each bit transfer pops the front.
//   The queue length is the pending-bit count, from which expected
//   out_valid / in_ready follow.
// ---------------------------------------------------------------------------
module tb_puncturer;

    localparam int CNT_W = 16;

    logic             i_clk;
    logic             i_rst;
    logic             i_frame_start;
    logic [1:0]       i_rate;
    logic             i_in_valid;
    logic             i_in_a;
    logic             i_in_b;
    logic             o_in_ready;
    logic             o_out_valid;
    logic             o_out_bit;
    logic             i_out_ready;
    logic [CNT_W-1:0] o_pairs_in;
    logic [CNT_W-1:0] o_bits_out;

    puncturer #(.CNT_W(CNT_W)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_frame_start (i_frame_start),
        .i_rate        (i_rate),
        .i_in_valid    (i_in_valid),
        .i_in_a        (i_in_a),
        .i_in_b        (i_in_b),
        .o_in_ready    (o_in_ready),
        .o_out_valid   (o_out_valid),
        .o_out_bit     (o_out_bit),
        .i_out_ready   (i_out_ready),
        .o_pairs_in    (o_pairs_in),
        .o_bits_out    (o_bits_out)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // scoreboard / model state
    logic [0:0] exp_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         m_rate = 0;   // 0 = 1/2, 1 = 2/3, 2 = 3/4
    int         m_idx  = 0;   // pairs accepted since frame start
    bit         m_alive = 0;
    int         m_pairs = 0;
    int         m_bits  = 0;
    logic [63:0] cap;
    int          cap_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_idx   = 0;
        m_pairs = 0;
        m_bits  = 0;
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle against the
    // model, update the model, then move to just after the next edge.
    task automatic cycle(input logic fs, input logic [1:0] rt, input logic iv,
                         input logic a, input logic b, input logic ordy,
                         output logic acc);
        bit exp_ov, exp_ir, keep_a, keep_b;
        int period, ph;
        i_frame_start = fs;
        i_rate        = rt;
        i_in_valid    = iv;
        i_in_a        = a;
        i_in_b        = b;
        i_out_ready   = ordy;
        acc           = 1'b0;
        #4;
        exp_ov = (exp_q.size() != 0);
        exp_ir = m_alive && !fs && (exp_q.size() == 0 || (exp_q.size() == 1 && ordy));
        check("out_valid", {31'd0, o_out_valid}, {31'd0, exp_ov});
        check("in_ready",  {31'd0, o_in_ready},  {31'd0, exp_ir});
        if (exp_ov)
            check("out_bit", {31'd0, o_out_bit}, {31'd0, exp_q[0]});
`ifdef PUNCT_STATS_EN
        check("pairs_in", {16'd0, o_pairs_in}, m_pairs);
        check("bits_out", {16'd0, o_bits_out}, m_bits);
`else
        check("pairs_in", {16'd0, o_pairs_in}, 0);
        check("bits_out", {16'd0, o_bits_out}, 0);
`endif
        if (fs) begin
            model_clear();
            m_rate = (rt == 2'b11) ? 0 : int'(rt);
        end else begin
            if (exp_ov && ordy) begin
                cap = {cap[62:0], o_out_bit};
                cap_n++;
                void'(exp_q.pop_front());
                if (m_bits < 65535) m_bits++;
            end
            if (iv && exp_ir) begin
                period = m_rate + 1;
                ph     = m_idx % period;
                keep_a = !(m_rate == 2 && ph == 2);
                keep_b = (ph != 1);
                if (keep_a) exp_q.push_back(a);
                if (keep_b) exp_q.push_back(b);
                m_idx++;
                if (m_pairs < 65535) m_pairs++;
                acc = 1'b1;
            end
        end
        m_alive = 1;
        @(posedge i_clk);
        #1;
    endtask

    // driver tasks
    task automatic idle(input logic ordy);
        logic acc;
        cycle(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, ordy, acc);
    endtask

    task automatic frame(input logic [1:0] rt, input logic ordy);
        logic acc;
        cycle(1'b1, rt, 1'b0, 1'b0, 1'b0, ordy, acc);
        cap   = '0;
        cap_n = 0;
    endtask

    task automatic send_pair(input logic a, input logic b, input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 30 && !acc; t++)
            cycle(1'b0, 2'($urandom_range(0, 3)), 1'b1, a, b, ordy, acc);
        check("send_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) idle(1'b1);
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_cap(input string tag, input logic [63:0] exp_bits, input int exp_n);
        check({tag, "_count"}, cap_n, exp_n);
        check(tag, cap[31:0], exp_bits[31:0]);
    endtask

    task automatic do_reset();
        #2;
        i_rst = 1'b1;
        #1;
        check("rst_in_ready",  {31'd0, o_in_ready},  32'd0);
        check("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
        check("rst_out_bit",   {31'd0, o_out_bit},   32'd0);
        check("rst_pairs_in",  {16'd0, o_pairs_in},  32'd0);
        check("rst_bits_out",  {16'd0, o_bits_out},  32'd0);
        @(posedge i_clk);
        #1;
        i_rst   = 1'b0;
        model_clear();
        m_rate  = 0;
        m_alive = 0;
    endtask

    initial begin
        logic acc;
        i_rst = 1'b1; i_frame_start = 1'b0; i_rate = 2'b00;
        i_in_valid = 1'b0; i_in_a = 1'b0; i_in_b = 1'b0; i_out_ready = 1'b0;
        cap = '0; cap_n = 0;
        #1;
        check("init_in_ready",  {31'd0, o_in_ready},  32'd0);
        check("init_out_valid", {31'd0, o_out_valid}, 32'd0);
        check("init_out_bit",   {31'd0, o_out_bit},   32'd0);
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst = 1'b0;
        idle(1'b1);                      // in_ready still 0 in this cycle
        idle(1'b1);

        // rate 1/2 back to back
        frame(2'b00, 1'b1);
        send_pair(1, 0, 1); send_pair(0, 1, 1); send_pair(1, 1, 1); send_pair(0, 0, 1);
        drain();
        check_cap("r12_seq", 64'b10011100, 8);

        // rate 2/3
        frame(2'b01, 1'b1);
        send_pair(1, 0, 1); send_pair(1, 1, 1); send_pair(0, 1, 1); send_pair(0, 0, 1);
        drain();
        check_cap("r23_seq", 64'b101010, 6);

        // rate 3/4, two pattern periods
        frame(2'b10, 1'b1);
        send_pair(1, 1, 1); send_pair(0, 1, 1); send_pair(1, 0, 1);
        send_pair(0, 0, 1); send_pair(1, 0, 1); send_pair(0, 1, 1);
        drain();
        check_cap("r34_seq", 64'b11000011, 8);

        // rate 3/4 with 5 cycles of backpressure mid-pair
        frame(2'b10, 1'b1);
        send_pair(1, 0, 1);
        idle(1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, acc);
        send_pair(1, 1, 1); send_pair(0, 1, 1);
        drain();
        check_cap("bp_seq", 64'b1011, 4);

        // frame_start discards a pending bit and switches to 2/3
        frame(2'b10, 1'b1);
        send_pair(1, 1, 1);
        drain();
        send_pair(0, 1, 0);
        idle(1'b0);
        frame(2'b01, 1'b0);
        idle(1'b1);
        send_pair(1, 1, 1); send_pair(1, 0, 1);
        drain();
        check_cap("fs_seq", 64'b111, 3);

        // randomized traffic with random rate input and occasional frame_start
        for (int k = 0; k < 1500; k++) begin
            cycle(($urandom_range(0, 59) == 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), acc);
        end

        // reset mid-stream, then a counted rate 3/4 frame
        frame(2'b10, 1'b1);
        send_pair(1, 1, 1);
        do_reset();
        idle(1'b1);
        idle(1'b1);
        frame(2'b10, 1'b1);
        for (int k = 0; k < 24; k++)
            send_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        drain();
        idle(1'b1);
        check("stat_bits_total", cap_n, 32);
`ifdef PUNCT_STATS_EN
        check("stat_pairs_24", {16'd0, o_pairs_in}, 32'd24);
        check("stat_bits_32",  {16'd0, o_bits_out}, 32'd32);
`else
        check("stat_pairs_off", {16'd0, o_pairs_in}, 32'd0);
        check("stat_bits_off",  {16'd0, o_bits_out}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
